note_dispatcher: RTL and testbench

Initiator side of the note-player load interface. It pulls note items from the song reader and assigns each note to a free note player with a one-cycle `load_new_note` pulse, using round-robin selection. It also paces the song by counting beats on wait items, so that notes issued between two wait items sound together as a chord. It sits between the song ROM reader and the bank of note players, and feeds the playing status of each player back into its selection logic.

---
 rtl/note_dispatch_pkg.sv | 15 +
 rtl/note_dispatcher_if.sv | 41 ++++
 rtl/rr_free_picker.sv | 34 +++
 rtl/note_dispatcher.sv | 144 ++++++++++++++
 tb/tb_note_dispatcher.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_dispatch_pkg.sv
// Shared widths, rest encoding and dispatcher state codes for the note dispatcher.
package note_dispatch_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;

    typedef logic [1:0] state_t;

    localparam state_t FETCH    = 2'd0;
    localparam state_t DISPATCH = 2'd1;
    localparam state_t WAIT     = 2'd2;

endpackage

// File: rtl/note_dispatcher_if.sv
// Song-item handshake from the song reader plus the load bus into the note players.
interface note_dispatcher_if #(
    parameter int unsigned NUM_PLAYERS = 3
);
    import note_dispatch_pkg::*;

    logic                   note_valid;
    logic                   note_ready;
    logic                   item_is_wait;
    logic [NOTE_W-1:0]      note_in;
    logic [DUR_W-1:0]       duration_in;
    logic [NUM_PLAYERS-1:0] player_playing;
    logic [NUM_PLAYERS-1:0] load_new_note;
    logic [NOTE_W-1:0]      note_to_load;
    logic [DUR_W-1:0]       duration_to_load;

    modport master (
        input  note_valid,
        input  item_is_wait,
        input  note_in,
        input  duration_in,
        input  player_playing,
        output note_ready,
        output load_new_note,
        output note_to_load,
        output duration_to_load
    );

    modport slave (
        output note_valid,
        output item_is_wait,
        output note_in,
        output duration_in,
        output player_playing,
        input  note_ready,
        input  load_new_note,
        input  note_to_load,
        input  duration_to_load
    );

endinterface

// File: rtl/rr_free_picker.sv
// Combinational round-robin picker: grants the first set bit of `free` at or after rr_ptr.
module rr_free_picker #(
    parameter int unsigned  NUM_PLAYERS = 3,
    localparam int unsigned PTR_W       = $clog2(NUM_PLAYERS)
) (
    input  logic [NUM_PLAYERS-1:0] free,
    input  logic [PTR_W-1:0]       rr_ptr,
    output logic [NUM_PLAYERS-1:0] grant,
    output logic                   any_free
);

    logic [NUM_PLAYERS-1:0] upper;
    logic [NUM_PLAYERS-1:0] pool;
    logic                   taken;

    // Search the indices at/after rr_ptr first; fall back to the wrapped-around low part.
    always_comb begin
        upper = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            upper[i] = free[i] && (PTR_W'(i) >= rr_ptr);
        end
        pool  = (|upper) ? upper : free;
        grant = '0;
        taken = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (pool[i] && !taken) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
            end
        end
        any_free = |free;
    end

endmodule

// File: rtl/note_dispatcher.sv
// Pulls song items, assigns notes round-robin to free note players and paces waits by beats.
// Optional NOTE_STEAL_EN: when no player is free, reload player rr_ptr instead of stalling.
module note_dispatcher
    import note_dispatch_pkg::*;
#(
    parameter int unsigned  NUM_PLAYERS = 3,
    localparam int unsigned PTR_W       = $clog2(NUM_PLAYERS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play_enable,
    input  logic                     beat,
    note_dispatcher_if.master        bus,
    output logic                     dispatch_stall
);

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       grant_idx;
    logic [NUM_PLAYERS-1:0] pending_q, pending_d;
    logic [NUM_PLAYERS-1:0] load_q, load_d;
    logic [NUM_PLAYERS-1:0] free, free_grant, load_grant;
    logic                   any_free, fire, accept;
    logic [DUR_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [NOTE_W-1:0]      hold_note_q, hold_note_d, note_q, note_d;
    logic [DUR_W-1:0]       hold_dur_q, hold_dur_d, dur_q, dur_d;

    // A loaded player stays unavailable until its playing flag has been seen high.
    assign free   = ~bus.player_playing & ~pending_q;
    assign accept = (state_q == FETCH) && play_enable && bus.note_valid;

    rr_free_picker #(
        .NUM_PLAYERS(NUM_PLAYERS)
    ) u_picker (
        .free     (free),
        .rr_ptr   (rr_ptr_q),
        .grant    (free_grant),
        .any_free (any_free)
    );

`ifdef NOTE_STEAL_EN
    logic [NUM_PLAYERS-1:0] steal_grant;
    logic                   steal_any;

    // An all-ones mask makes the picker return the one-hot of rr_ptr itself.
    rr_free_picker #(
        .NUM_PLAYERS(NUM_PLAYERS)
    ) u_steal_picker (
        .free     ({NUM_PLAYERS{1'b1}}),
        .rr_ptr   (rr_ptr_q),
        .grant    (steal_grant),
        .any_free (steal_any)
    );

    assign load_grant     = any_free ? free_grant : steal_grant;
    assign fire           = (state_q == DISPATCH) && play_enable && (any_free || steal_any);
    assign dispatch_stall = 1'b0;
`else
    assign load_grant     = free_grant;
    assign fire           = (state_q == DISPATCH) && play_enable && any_free;
    assign dispatch_stall = (state_q == DISPATCH) && !any_free;
`endif

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (load_grant[i]) grant_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        hold_note_d = hold_note_q;
        hold_dur_d  = hold_dur_q;
        note_d      = note_q;
        dur_d       = dur_q;
        load_d      = '0;
        case (state_q)
            FETCH: begin
                if (accept) begin
                    if (bus.item_is_wait) begin
                        if (bus.duration_in != '0) begin
                            wait_cnt_d = bus.duration_in;
                            state_d    = WAIT;
                        end
                    end else if (bus.note_in != NOTE_REST && bus.duration_in != '0) begin
                        hold_note_d = bus.note_in;
                        hold_dur_d  = bus.duration_in;
                        state_d     = DISPATCH;
                    end
                end
            end
            DISPATCH: begin
                if (fire) begin
                    load_d   = load_grant;
                    note_d   = hold_note_q;
                    dur_d    = hold_dur_q;
                    rr_ptr_d = (grant_idx == PTR_W'(NUM_PLAYERS - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = FETCH;
                end
            end
            WAIT: begin
                if (beat && play_enable) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                    if (wait_cnt_q == 6'd1) state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        pending_d = (pending_q & ~bus.player_playing) | load_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            rr_ptr_q    <= '0;
            pending_q   <= '0;
            wait_cnt_q  <= '0;
            hold_note_q <= '0;
            hold_dur_q  <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            load_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
            wait_cnt_q  <= wait_cnt_d;
            hold_note_q <= hold_note_d;
            hold_dur_q  <= hold_dur_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            load_q      <= load_d;
        end
    end

    assign bus.note_ready       = (state_q == FETCH) && play_enable;
    assign bus.load_new_note    = load_q;
    assign bus.note_to_load     = note_q;
    assign bus.duration_to_load = dur_q;

endmodule

// File: tb/tb_note_dispatcher.sv
// Self-checking bench for note_dispatcher: directed table, corner sequences, random vs model.
module tb_note_dispatcher;
    import note_dispatch_pkg::*;

    localparam int NP = 3;

    logic clk = 1'b0;
    logic reset;
    logic play_enable;
    logic beat;
    logic dispatch_stall;

    note_dispatcher_if #(.NUM_PLAYERS(NP)) bus_if ();

    note_dispatcher #(.NUM_PLAYERS(NP)) dut (
        .clk            (clk),
        .reset          (reset),
        .play_enable    (play_enable),
        .beat           (beat),
        .bus            (bus_if),
        .dispatch_stall (dispatch_stall)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.note_valid     = 1'b0;
        bus_if.item_is_wait   = 1'b0;
        bus_if.note_in        = '0;
        bus_if.duration_in    = '0;
        bus_if.player_playing = '0;
        beat                  = 1'b0;
        play_enable           = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Present one item until accepted; returns at the falling edge after the accepting edge.
    task automatic send_item(input bit w, input logic [5:0] n, input logic [5:0] d,
                             input string tag);
        bit ok = 1'b0;
        bus_if.item_is_wait = w;
        bus_if.note_in      = n;
        bus_if.duration_in  = d;
        bus_if.note_valid   = 1'b1;
        for (int t = 0; t < 64 && !ok; t++) begin
            #1;
            if (bus_if.note_ready) ok = 1'b1;
            @(negedge clk);
        end
        bus_if.note_valid = 1'b0;
        check({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic clear_pending();
        bus_if.player_playing = '1;
        @(negedge clk);
        bus_if.player_playing = '0;
        @(negedge clk);
    endtask

    // ---------------- behavioural reference model ----------------
    int m_state;  // 0 fetching, 1 holding a note, 2 counting beats
    int m_ptr, m_wait, m_hn, m_hd, m_note, m_dur, m_load;
    bit m_pend[NP];

    function automatic void model_reset();
        m_state = 0; m_ptr = 0; m_wait = 0; m_hn = 0; m_hd = 0;
        m_note = 0; m_dur = 0; m_load = -1;
        for (int i = 0; i < NP; i++) m_pend[i] = 1'b0;
    endfunction

    function automatic bit m_free(input int i);
        return !bus_if.player_playing[i] && !m_pend[i];
    endfunction

    function automatic bit model_stall();
`ifdef NOTE_STEAL_EN
        return 1'b0;
`else
        bit any = 1'b0;
        for (int i = 0; i < NP; i++) if (m_free(i)) any = 1'b1;
        return (m_state == 1) && !any;
`endif
    endfunction

    function automatic void model_step();
        int k = -1;
        int n = int'(bus_if.note_in);
        int d = int'(bus_if.duration_in);
        case (m_state)
            0: if (play_enable && bus_if.note_valid) begin
                if (bus_if.item_is_wait) begin
                    if (d != 0) begin m_wait = d; m_state = 2; end
                end else if (n != 0 && d != 0) begin
                    m_hn = n; m_hd = d; m_state = 1;
                end
            end
            1: if (play_enable) begin
                for (int o = 0; o < NP; o++) begin
                    int idx = (m_ptr + o) % NP;
                    if (k < 0 && m_free(idx)) k = idx;
                end
`ifdef NOTE_STEAL_EN
                if (k < 0) k = m_ptr;
`endif
                if (k >= 0) begin
                    m_note = m_hn; m_dur = m_hd; m_ptr = (k + 1) % NP; m_state = 0;
                end
            end
            default: if (play_enable && beat) begin
                m_wait--;
                if (m_wait == 0) m_state = 0;
            end
        endcase
        for (int i = 0; i < NP; i++) begin
            if (i == k) m_pend[i] = 1'b1;
            else if (bus_if.player_playing[i]) m_pend[i] = 1'b0;
        end
        m_load = k;
    endfunction

    typedef struct {
        bit         is_wait;
        logic [5:0] note;
        logic [5:0] dur;
        logic       ready_after;
        logic [2:0] load;
        logic [5:0] exp_note;
        logic [5:0] exp_dur;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b0;
        idle_inputs();
        play_enable = 1'b0;
        @(negedge clk);
        #1;
        check("rst_ready",  32'(bus_if.note_ready), 32'd0);
        check("rst_load",   32'(bus_if.load_new_note), 32'd0);
        check("rst_note",   32'(bus_if.note_to_load), 32'd0);
        check("rst_dur",    32'(bus_if.duration_to_load), 32'd0);
        check("rst_stall",  32'(dispatch_stall), 32'd0);
        play_enable = 1'b1;
        #1;
        check("rst_fetch_ready", 32'(bus_if.note_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- table-driven single items ----------------
        vecs[0] = '{1'b0, 6'd5,  6'd10, 1'b0, 3'b001, 6'd5,  6'd10};
        vecs[1] = '{1'b0, 6'd0,  6'd7,  1'b1, 3'b000, 6'd5,  6'd10};
        vecs[2] = '{1'b0, 6'd9,  6'd0,  1'b1, 3'b000, 6'd5,  6'd10};
        vecs[3] = '{1'b1, 6'd0,  6'd0,  1'b1, 3'b000, 6'd5,  6'd10};
        vecs[4] = '{1'b0, 6'd63, 6'd63, 1'b0, 3'b010, 6'd63, 6'd63};
        vecs[5] = '{1'b0, 6'd1,  6'd1,  1'b0, 3'b100, 6'd1,  6'd1};
        vecs[6] = '{1'b0, 6'd20, 6'd3,  1'b0, 3'b001, 6'd20, 6'd3};
        vecs[7] = '{1'b0, 6'd2,  6'd40, 1'b0, 3'b010, 6'd2,  6'd40};
        do_reset();
        for (int v = 0; v < 8; v++) begin
            bus_if.item_is_wait = vecs[v].is_wait;
            bus_if.note_in      = vecs[v].note;
            bus_if.duration_in  = vecs[v].dur;
            bus_if.note_valid   = 1'b1;
            #1;
            check($sformatf("tbl%0d_ready", v), 32'(bus_if.note_ready), 32'd1);
            @(negedge clk);
            bus_if.note_valid = 1'b0;
            #1;
            check($sformatf("tbl%0d_ready_after", v), 32'(bus_if.note_ready),
                  32'(vecs[v].ready_after));
            check($sformatf("tbl%0d_load_early", v), 32'(bus_if.load_new_note), 32'd0);
            @(negedge clk);
            check($sformatf("tbl%0d_load", v), 32'(bus_if.load_new_note), 32'(vecs[v].load));
            check($sformatf("tbl%0d_note", v), 32'(bus_if.note_to_load), 32'(vecs[v].exp_note));
            check($sformatf("tbl%0d_dur", v), 32'(bus_if.duration_to_load),
                  32'(vecs[v].exp_dur));
            @(negedge clk);
            check($sformatf("tbl%0d_pulse", v), 32'(bus_if.load_new_note), 32'd0);
            clear_pending();
        end

        // ---------------- three notes then a wait of 4 beats ----------------
        do_reset();
        send_item(1'b0, 6'd5, 6'd10, "b_n0");
        #1;
        check("b_n0_ready_low", 32'(bus_if.note_ready), 32'd0);
        check("b_n0_no_early",  32'(bus_if.load_new_note), 32'd0);
        @(negedge clk);
        check("b_n0_load", 32'(bus_if.load_new_note), 32'b001);
        check("b_n0_note", 32'(bus_if.note_to_load), 32'd5);
        check("b_n0_dur",  32'(bus_if.duration_to_load), 32'd10);
        send_item(1'b0, 6'd7, 6'd3, "b_n1");
        @(negedge clk);
        check("b_n1_load", 32'(bus_if.load_new_note), 32'b010);
        send_item(1'b0, 6'd9, 6'd4, "b_n2");
        @(negedge clk);
        check("b_n2_load", 32'(bus_if.load_new_note), 32'b100);
        beat = 1'b1;  // beat in the accept cycle must not count
        send_item(1'b1, 6'd0, 6'd4, "b_wait");
        beat = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            beat = 1'b1;
            @(negedge clk);
            beat = 1'b0;
            #1;
            check($sformatf("b_wait_ready_beat%0d", b), 32'(bus_if.note_ready), 32'(b == 4));
            @(negedge clk);
        end

        // ---------------- all players busy ----------------
        bus_if.player_playing = 3'b111;
        @(negedge clk);
        send_item(1'b0, 6'd33, 6'd12, "c_note");
        #1;
`ifdef NOTE_STEAL_EN
        check("c_steal_no_stall", 32'(dispatch_stall), 32'd0);
        @(negedge clk);
        check("c_steal_load",  32'(bus_if.load_new_note), 32'b001);
        check("c_steal_note",  32'(bus_if.note_to_load), 32'd33);
        check("c_steal_dur",   32'(bus_if.duration_to_load), 32'd12);
        check("c_steal_stall", 32'(dispatch_stall), 32'd0);
`else
        check("c_stall", 32'(dispatch_stall), 32'd1);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check($sformatf("c_stall_hold%0d", t), 32'(dispatch_stall), 32'd1);
            check($sformatf("c_no_load%0d", t), 32'(bus_if.load_new_note), 32'd0);
        end
        bus_if.player_playing = 3'b101;
        #1;
        check("c_stall_drop", 32'(dispatch_stall), 32'd0);
        @(negedge clk);
        check("c_load", 32'(bus_if.load_new_note), 32'b010);
        check("c_note", 32'(bus_if.note_to_load), 32'd33);
        check("c_dur",  32'(bus_if.duration_to_load), 32'd12);
`endif
        clear_pending();

        // ---------------- play_enable low in WAIT and DISPATCH ----------------
        send_item(1'b1, 6'd0, 6'd2, "d_wait");
        play_enable = 1'b0;
        repeat (3) begin
            beat = 1'b1;
            @(negedge clk);
            beat = 1'b0;
            @(negedge clk);
        end
        play_enable = 1'b1;
        #1;
        check("d_wait_frozen", 32'(bus_if.note_ready), 32'd0);
        for (int b = 1; b <= 2; b++) begin
            beat = 1'b1;
            @(negedge clk);
            beat = 1'b0;
            #1;
            check($sformatf("d_wait_beat%0d", b), 32'(bus_if.note_ready), 32'(b == 2));
            @(negedge clk);
        end
        send_item(1'b0, 6'd12, 6'd5, "d_note");
        play_enable = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check($sformatf("d_disp_frozen%0d", t), 32'(bus_if.load_new_note), 32'd0);
        end
        play_enable = 1'b1;
        @(negedge clk);
`ifdef NOTE_STEAL_EN
        check("d_resume_load", 32'(bus_if.load_new_note), 32'b010);
`else
        check("d_resume_load", 32'(bus_if.load_new_note), 32'b100);
`endif
        check("d_resume_note", 32'(bus_if.note_to_load), 32'd12);
        check("d_resume_dur",  32'(bus_if.duration_to_load), 32'd5);
        clear_pending();
        send_item(1'b0, 6'd40, 6'd7, "d_rst_note");
        reset = 1'b0;
        #1;
        check("d_rst_load",  32'(bus_if.load_new_note), 32'd0);
        check("d_rst_note",  32'(bus_if.note_to_load), 32'd0);
        check("d_rst_dur",   32'(bus_if.duration_to_load), 32'd0);
        check("d_rst_stall", 32'(dispatch_stall), 32'd0);
        check("d_rst_ready", 32'(bus_if.note_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("d_discarded", 32'(bus_if.load_new_note), 32'd0);
        check("d_post_ready", 32'(bus_if.note_ready), 32'd1);

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            check("rnd_load", 32'(bus_if.load_new_note), (m_load < 0) ? 32'd0 : (32'd1 << m_load));
            check("rnd_note", 32'(bus_if.note_to_load), 32'(m_note));
            check("rnd_dur",  32'(bus_if.duration_to_load), 32'(m_dur));
            play_enable         = ($urandom_range(0, 9) != 0);
            beat                = ($urandom_range(0, 3) == 0);
            bus_if.note_valid   = ($urandom_range(0, 2) != 0);
            bus_if.item_is_wait = ($urandom_range(0, 4) == 0);
            bus_if.note_in      = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            if (bus_if.item_is_wait) bus_if.duration_in = 6'($urandom_range(0, 3));
            else bus_if.duration_in = ($urandom_range(0, 5) == 0) ? 6'd0 :
                                      6'($urandom_range(1, 63));
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 3) == 0)
                    bus_if.player_playing[i] = ~bus_if.player_playing[i];
            end
            #1;
            check("rnd_ready", 32'(bus_if.note_ready), 32'((m_state == 0) && play_enable));
            check("rnd_stall", 32'(dispatch_stall), 32'(model_stall()));
            model_step();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
